// File: rtl/new_proj_pkg.sv
// new_proj_pkg
//   Shared definitions for the synchronous FIFO slice.
//   - DEFAULT_DATASIZE / DEFAULT_ADDRSIZE : default word width and pointer width
//   - fifo_mode_e                         : read-path flavour (REG_READ or FWFT)
//   - sticky_next()                       : next value of a sticky error flag
package new_proj_pkg;

  localparam int DEFAULT_DATASIZE = 8;
  localparam int DEFAULT_ADDRSIZE = 4;

  typedef enum logic {
    REG_READ = 1'b0,
    FWFT     = 1'b1
  } fifo_mode_e;

  // A set request in the same cycle as a clear keeps the flag asserted.
  function automatic logic sticky_next(input logic cur, input logic set_req, input logic clr_req);
    return set_req | (cur & ~clr_req);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
//   DEPTH x DATASIZE storage array for custom_sync_fifo.
//   Synchronous write port, asynchronous (combinational) read port, no reset.
// Ports
//   clk_i  : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data, follows raddr combinationally
module fifo_mem
  import new_proj_pkg::*;
#(
  parameter int DATASIZE = DEFAULT_DATASIZE,
  parameter int ADDRSIZE = DEFAULT_ADDRSIZE
) (
  input  logic                clk_i,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/custom_sync_fifo.sv
// custom_sync_fifo
//   Single-clock FIFO with registered-read or first-word-fall-through output,
//   occupancy-derived status flags and sticky overflow/underflow flags.
// Parameters
//   DATASIZE : word width
//   ADDRSIZE : pointer width, DEPTH = 2**ADDRSIZE
//   FWFT     : 0 = registered read (latency 1), 1 = first-word-fall-through
//   AF_LEVEL : almost_full when occupancy >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL : almost_empty when occupancy <= AE_LEVEL (0..DEPTH-1)
// Ports
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   din, wen               : write data / write request
//   ren                    : read request
//   err_clr                : synchronous clear of overflow/underflow
//   dout                   : read data
//   fifo_full, fifo_empty  : occupancy == DEPTH / == 0
//   almost_full/empty      : threshold flags
//   fill_level             : occupancy, 0..DEPTH
//   overflow, underflow    : sticky dropped-write / dropped-read flags
module custom_sync_fifo
  import new_proj_pkg::*;
#(
  parameter int DATASIZE = DEFAULT_DATASIZE,
  parameter int ADDRSIZE = DEFAULT_ADDRSIZE,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = (1 << ADDRSIZE) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DATASIZE-1:0] din,
  input  logic                wen,
  input  logic                ren,
  input  logic                err_clr,
  output logic [DATASIZE-1:0] dout,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   fill_level,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam fifo_mode_e MODE = (FWFT != 0) ? new_proj_pkg::FWFT : REG_READ;

  localparam logic [ADDRSIZE:0] DEPTH_CNT = {1'b1, {ADDRSIZE{1'b0}}};
  localparam logic [ADDRSIZE:0] AF_CNT    = AF_LEVEL[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] AE_CNT    = AE_LEVEL[ADDRSIZE:0];

  // Threshold sanity: anything outside the legal ranges stops elaboration.
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_range
    $error("custom_sync_fifo: AF_LEVEL=%0d outside 1..%0d", AF_LEVEL, DEPTH);
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_ae_range
    $error("custom_sync_fifo: AE_LEVEL=%0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
  end

  logic [ADDRSIZE-1:0] wr_ptr;
  logic [ADDRSIZE-1:0] rd_ptr;
  logic [ADDRSIZE:0]   count;
  logic [DATASIZE-1:0] rdata;
  logic [DATASIZE-1:0] rd_word_p1;

  logic rd_acc;
  logic wr_acc;
  logic ovf_set;
  logic udf_set;

  // ---- stage p0: request qualification against the registered occupancy ----
  // A write into a full FIFO is still taken when a read frees a slot on the
  // same edge, so the read decision must be made first.
  assign rd_acc  = ren & ~fifo_empty;
  assign wr_acc  = wen & (~fifo_full | rd_acc);
  assign ovf_set = wen & fifo_full & ~rd_acc;
  assign udf_set = ren & fifo_empty;

  fifo_mem #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .clk_i (clk_i),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // ---- stage p1: pointer, occupancy and error-flag state ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow  <= sticky_next(overflow, ovf_set, err_clr);
      underflow <= sticky_next(underflow, udf_set, err_clr);
    end
  end

  // Word popped by the most recent accepted read. In registered-read mode this
  // is the output; in FWFT mode it is what dout holds while the FIFO is empty,
  // which also hides stale array contents after a reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_word_p1 <= '0;
    end else if (rd_acc) begin
      rd_word_p1 <= rdata;
    end
  end

  // ---- stage p1 outputs: everything below follows the registered state ----
  assign fill_level   = count;
  assign fifo_full    = (count == DEPTH_CNT);
  assign fifo_empty   = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  if (MODE == new_proj_pkg::FWFT) begin : g_fwft
    assign dout = fifo_empty ? rd_word_p1 : rdata;
  end else begin : g_reg_read
    assign dout = rd_word_p1;
  end

endmodule

// File: tb/tb_custom_sync_fifo.sv
module tb_custom_sync_fifo;

  typedef struct {
    logic       wen;
    logic       ren;
    logic       clr;
    logic [7:0] din;
    int         fill;
    logic       ovf;
    logic       udf;
    logic [7:0] d0;
    logic [7:0] d1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dout0, dout1;
  logic [4:0] fill0, fill1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;

  int checks = 0;
  int errors = 0;

  vec_t       tbl[$];
  logic [7:0] model[$];
  logic [7:0] exp_word;

  always #5 clk = ~clk;

  custom_sync_fifo #(
    .DATASIZE (8), .ADDRSIZE (4), .FWFT (0), .AF_LEVEL (14), .AE_LEVEL (2)
  ) u_reg (
    .clk_i (clk), .rst_i (rst), .din (din), .wen (wen), .ren (ren),
    .err_clr (err_clr), .dout (dout0), .fifo_full (full0), .fifo_empty (empty0),
    .almost_full (af0), .almost_empty (ae0), .fill_level (fill0),
    .overflow (ovf0), .underflow (udf0)
  );

  custom_sync_fifo #(
    .DATASIZE (8), .ADDRSIZE (4), .FWFT (1), .AF_LEVEL (14), .AE_LEVEL (2)
  ) u_fwft (
    .clk_i (clk), .rst_i (rst), .din (din), .wen (wen), .ren (ren),
    .err_clr (err_clr), .dout (dout1), .fifo_full (full1), .fifo_empty (empty1),
    .almost_full (af1), .almost_empty (ae1), .fill_level (fill1),
    .overflow (ovf1), .underflow (udf1)
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  // Flags are derived here from the expected occupancy using the thresholds
  // AF=14, AE=2, DEPTH=16: {full, empty, almost_full, almost_empty, ovf, udf}.
  task automatic check_all(input string nm, input int idx, input int f, input logic ovf,
                           input logic udf, input logic [7:0] d0, input logic [7:0] d1);
    logic [5:0] ef;
    ef = {f == 16, f == 0, f >= 14, f <= 2, ovf, udf};
    chk({nm, ".fill_reg"},  idx, 32'(fill0), 32'(f));
    chk({nm, ".fill_fwft"}, idx, 32'(fill1), 32'(f));
    chk({nm, ".flags_reg"},  idx, 32'({full0, empty0, af0, ae0, ovf0, udf0}), 32'(ef));
    chk({nm, ".flags_fwft"}, idx, 32'({full1, empty1, af1, ae1, ovf1, udf1}), 32'(ef));
    chk({nm, ".dout_reg"},  idx, 32'(dout0), 32'(d0));
    chk({nm, ".dout_fwft"}, idx, 32'(dout1), 32'(d1));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic c, input logic [7:0] d);
    wen     = w;
    ren     = r;
    err_clr = c;
    din     = d;
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic c, input logic [7:0] d,
                              input int f, input logic o, input logic u,
                              input logic [7:0] e0, input logic [7:0] e1);
    vec_t v;
    v.wen = w; v.ren = r; v.clr = c; v.din = d;
    v.fill = f; v.ovf = o; v.udf = u; v.d0 = e0; v.d1 = e1;
    return v;
  endfunction

  // Asynchronous reset pulse placed between clock edges; outputs are checked
  // while rst is high and before any further edge.
  task automatic async_reset(input string nm);
    #2 rst = 1'b1;
    #1 check_all(nm, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    #2 rst = 1'b0;
  endtask

  initial begin
    // ---------------- table: fill, overflow, clear, drain, underflow --------
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1, 0, 0, 8'(i + 1), i + 1, 0, 0, 8'h00, 8'h01));
    tbl.push_back(mk(1, 0, 0, 8'h11, 16, 1, 0, 8'h00, 8'h01));   // 17th write dropped
    tbl.push_back(mk(0, 0, 1, 8'h00, 16, 0, 0, 8'h00, 8'h01));   // clear
    tbl.push_back(mk(1, 0, 1, 8'h22, 16, 1, 0, 8'h00, 8'h01));   // set beats clear
    for (int j = 0; j < 16; j++)
      tbl.push_back(mk(0, 1, 0, 8'h00, 15 - j, 1, 0, 8'(j + 1),
                       (j == 15) ? 8'h10 : 8'(j + 2)));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 1, 8'h10, 8'h10));    // read at empty
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0, 8'h10, 8'h10));    // clear both

    #3 check_all("reset", 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    #1 rst = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].wen, tbl[k].ren, tbl[k].clr, tbl[k].din);
      cyc();
      check_all("vec", k, tbl[k].fill, tbl[k].ovf, tbl[k].udf, tbl[k].d0, tbl[k].d1);
    end
    drive(0, 0, 0, 8'h00);

    // ---------------- read+write at empty, mid-stream reset, FWFT single word
    async_reset("rst_a");
    drive(1, 1, 0, 8'h5A);
    cyc();
    check_all("empty_wr_rd", 0, 1, 1'b0, 1'b1, 8'h00, 8'h5A);
    drive(0, 1, 0, 8'h00);
    cyc();
    check_all("pop_5a", 0, 0, 1'b0, 1'b1, 8'h5A, 8'h5A);
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, 0, 8'(8'h61 + i));
      cyc();
    end
    drive(0, 0, 0, 8'h00);
    check_all("seven", 0, 7, 1'b0, 1'b1, 8'h5A, 8'h61);
    async_reset("rst_mid");
    drive(1, 0, 0, 8'hA5);
    cyc();
    check_all("fwft_a5", 0, 1, 1'b0, 1'b0, 8'h00, 8'hA5);
    drive(0, 0, 0, 8'h00);
    cyc();
    check_all("idle_a5", 0, 1, 1'b0, 1'b0, 8'h00, 8'hA5);
    drive(0, 1, 0, 8'h00);
    cyc();
    check_all("pop_a5", 0, 0, 1'b0, 1'b0, 8'hA5, 8'hA5);
    cyc();
    check_all("udf_after_rst", 0, 0, 1'b0, 1'b1, 8'hA5, 8'hA5);
    drive(0, 0, 1, 8'h00);
    cyc();
    drive(0, 0, 0, 8'h00);

    // ---------------- full-rate read+write at full across pointer wrap ------
    async_reset("rst_b");
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 8'(8'h20 + i));
      model.push_back(8'(8'h20 + i));
      cyc();
    end
    check_all("full_b", 0, 16, 1'b0, 1'b0, 8'h00, 8'h20);
    for (int c = 0; c < 20; c++) begin
      drive(1, 1, 0, 8'(8'h40 + c));
      exp_word = model.pop_front();
      model.push_back(8'(8'h40 + c));
      cyc();
      check_all("stream", c, 16, 1'b0, 1'b0, exp_word, model[0]);
    end
    for (int c = 0; c < 16; c++) begin
      drive(0, 1, 0, 8'h00);
      exp_word = model.pop_front();
      cyc();
      check_all("drain", c, 15 - c, 1'b0, 1'b0, exp_word,
                (model.size() != 0) ? model[0] : exp_word);
    end
    drive(0, 0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/custom_sync_fifo.md
CUSTOM_SYNC_FIFO -- requirements
Module: custom_sync_fifo

Interface
REQ-001 Parameter DATASIZE, default 8, data word width in bits.
REQ-002 Parameter ADDRSIZE, default 4, pointer width; depth DEPTH = 2**ADDRSIZE.
REQ-003 Parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 Parameter AF_LEVEL, default DEPTH-2, almost-full threshold; legal range 1..DEPTH.
REQ-005 Parameter AE_LEVEL, default 2, almost-empty threshold; legal range 0..DEPTH-1.
REQ-006 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_i  input  1  reset; asynchronous, active-high.
REQ-008 din  input  DATASIZE  write data.
REQ-009 wen  input  1  write request.
REQ-010 ren  input  1  read request.
REQ-011 err_clr  input  1  synchronous clear of the sticky error flags.
REQ-012 dout  output  DATASIZE  read data.
REQ-013 fifo_full  output  1  occupancy == DEPTH.
REQ-014 fifo_empty  output  1  occupancy == 0.
REQ-015 almost_full  output  1  occupancy >= AF_LEVEL.
REQ-016 almost_empty  output  1  occupancy <= AE_LEVEL.
REQ-017 fill_level  output  ADDRSIZE+1  current occupancy, 0..DEPTH.
REQ-018 overflow  output  1  sticky: a write was dropped.
REQ-019 underflow  output  1  sticky: a read was dropped.

Function
REQ-020 A write is accepted when wen=1 and (fifo_full=0 or an accepted read occurs in the same cycle); the word is stored at wr_ptr and wr_ptr increments.
REQ-021 A read is accepted when ren=1 and fifo_empty=0; rd_ptr increments.
REQ-022 Pointers are ADDRSIZE bits and wrap from DEPTH-1 to 0 with no extra cycle.
REQ-023 Occupancy is a registered ADDRSIZE+1-bit counter: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-024 All flags and fill_level derive from the registered counter and reflect the new value one cycle after the accepting edge.
REQ-025 At full with wen=1 and ren=1, both are accepted and occupancy stays DEPTH.
REQ-026 At empty with wen=1 and ren=1, the write is accepted, the read is dropped and underflow sets.
REQ-027 FWFT=0: dout is registered, loads the word at rd_ptr on the edge accepting a read (latency 1), and holds at all other times.
REQ-028 FWFT=1: dout continuously shows the word at rd_ptr while fifo_empty=0; a word written into an empty FIFO appears on dout in the cycle after the write edge; ren pops the head.
REQ-029 FWFT=1 while empty: dout holds the last popped value (0 after reset).
REQ-030 overflow sets when wen=1, fifo_full=1 and no read is accepted in the same cycle.
REQ-031 underflow sets when ren=1 and fifo_empty=1.
REQ-032 err_clr clears both sticky flags; a set condition in the same cycle wins over the clear.
REQ-033 Out-of-range AF_LEVEL or AE_LEVEL shall cause an elaboration error.

Reset
REQ-034 rst_i=1 immediately forces wr_ptr=0, rd_ptr=0, fill_level=0, fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, dout=0, independent of clk_i.
REQ-035 Reset asserted mid-operation discards all contents; memory array contents are not reset and are never observable after reset.
REQ-036 The first write is accepted on the first rising clk_i edge after rst_i deasserts.

Structure
REQ-037 Default DATASIZE/ADDRSIZE values and the fifo mode enum (REG_READ, FWFT) shall live in new_proj_pkg.
REQ-038 Storage shall be a sub-module fifo_mem: DEPTH x DATASIZE array, synchronous write port, asynchronous read port, no reset.

Verification (DATASIZE=8, ADDRSIZE=4, AF_LEVEL=14, AE_LEVEL=2)
REQ-039 Reset, write 0x01..0x10 (16 words) -> fifo_full=1, fill_level=16, almost_full=1 from word 14; a 17th write sets overflow and is dropped.
REQ-040 FWFT=0, drain 16 reads -> dout=0x01..0x10 each one cycle after its read; fifo_empty=1; a further read sets underflow and dout holds 0x10.
REQ-041 At full, wen=1 and ren=1 for 20 cycles -> fill_level stays 16, no overflow, data order preserved across pointer wrap.
REQ-042 FWFT=1, single write of 0xA5 into empty -> dout=0xA5 and fifo_empty=0 in the next cycle with no ren.
REQ-043 Assert rst_i mid-stream with 7 words stored -> outputs take their REQ-034 values without a clock edge; a subsequent write then read returns the new word only.
REQ-044 overflow set, err_clr=1 -> cleared next cycle; err_clr=1 coincident with a dropped write -> overflow remains 1.
